mem_ctrl_multi: RTL
===================

Name: mem_ctrl_multi

Overview:
- Parametrised data-memory controller, successor to the single-shot RAM1/RAM2/COM1 controller in the MEM stage.
- Decodes one 16-bit CPU data request to one of:
  - RAM1 (low region)
  - one of NUM_UART memory-mapped UART channels
  - RAM2 (everything else).
- Adds a req/ack handshake, configurable SRAM wait states, UART status registers, transmit-done polling and multi-channel UART support.
- Drives the pipeline stall signal `busy` while an access is in flight.

Parameters:
- DATA_W, 16, CPU and SRAM data width
- RAM_AW, 18, SRAM address pin width; bits above 15 are driven 0
- RAM1_UPPER, 16'h8000, addresses below this go to RAM1
- UART_BASE, 16'hBF00, first UART register address
- NUM_UART, 2, UART channels (1..4). Channel i data reg = UART_BASE+2i; status reg = UART_BASE+2i+1.
- WAIT_STATES, 1, extra SRAM strobe cycles (0..7)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset
- req  in  1  access request; held by CPU until ack
- we  in  1  1=write, 0=read; sampled at accept
- addr  in  16  byte-free word address; sampled at accept
- wdata  in  DATA_W  write data; sampled at accept
- rdata  out  DATA_W  read result; valid when ack=1
- ack  out  1  one-cycle completion pulse
- busy  out  1  stall to pipeline: high from accept through ack cycle
- ram1_data  inout  DATA_W  RAM1 bus, shared by all UART channels on [7:0]
- ram1_addr  out  RAM_AW  RAM1 address
- ram1_en, ram1_oe, ram1_we  out  1 each  RAM1 strobes, active low
- ram2_data  inout  DATA_W  RAM2 bus
- ram2_addr  out  RAM_AW  RAM2 address
- ram2_en, ram2_oe, ram2_we  out  1 each  RAM2 strobes, active low
- uart_data_ready  in  NUM_UART  per-channel receive data ready
- uart_tbre, uart_tsre  in  NUM_UART each  per-channel transmit buffer/shift empty
- uart_rdn, uart_wrn  out  NUM_UART each  per-channel read/write strobes, active low

Behaviour:
- Reset (async, rst=0):
  - state=IDLE
  - all strobes (en/oe/we/rdn/wrn) = 1
  - both data buses tri-stated
  - addresses, rdata = 0
  - ack=0, busy=0
  - Takes effect immediately, including mid-access; no access completes.
- Accept: in IDLE with req=1, latch we/addr/wdata, set busy=1, decode target. req while busy is ignored. After ack, req must drop or a new access is accepted the next cycle.
- Decode priority:
  1. addr < RAM1_UPPER → RAM1
  2. UART_BASE <= addr < UART_BASE+8 → UART window; channel = (addr-UART_BASE)>>1
  3. else → RAM2
- UART window slots with channel >= NUM_UART: read returns 0, write is dropped, ack on next cycle.
- States: IDLE, SRAM_ACC, SRAM_HOLD, U_RD, U_WR, U_TXWAIT, DONE.
- SRAM read:
  - SRAM_ACC for WAIT_STATES+1 cycles with en=0, oe=0, we=1 and the bus tri-stated.
  - Data captured into rdata on the last SRAM_ACC cycle.
  - Then DONE (ack=1, strobes high).
  - Latency req-accept→ack = WAIT_STATES+2 cycles.
- SRAM write:
  - Bus driven with wdata from the first SRAM_ACC cycle.
  - en=0, we=0, oe=1 for WAIT_STATES+1 cycles.
  - SRAM_HOLD: one cycle with we=1, en=0 and bus still driven.
  - Then DONE.
  - Latency WAIT_STATES+3.
- The unused SRAM keeps en=1 and its bus tri-stated. RAM1 bus is tri-stated during UART reads and driven with {8'h00, wdata[7:0]} during UART writes.
- UART data read (U_RD):
  - If uart_data_ready[ch]=0 at accept: rdata=0, DONE next cycle, rdn not pulsed.
  - Else: rdn[ch]=0 for 2 cycles; capture ram1_data[7:0] on the 2nd; rdata[15:8]=0; then DONE.
- UART data write:
  - U_WR: wrn[ch]=0 for 1 cycle.
  - U_TXWAIT: wait until tbre[ch]&tsre[ch]=1, then DONE. No timeout; busy stays high.
- UART status read: rdata = {14'b0, uart_data_ready[ch], tbre[ch]&tsre[ch]}; DONE next cycle.
- UART status write: ignored, ack next cycle.
- Only the addressed channel's strobes ever go low.
- DONE: ack=1 for exactly one cycle, busy=1 in that cycle, then IDLE. rdata holds until the next read completes.
- Strobe outputs are registered (no glitches).

Test Plan:
- Reset during a RAM2 write mid-SRAM_ACC (WAIT_STATES=3) → ram2_we/en rise to 1 and ram2_data goes Z in the same time step; no ack afterwards.
- WAIT_STATES=1: write 16'hBEEF to 16'h0100, then read 16'h0100 → write ack 4 cycles after accept, ram1_addr=18'h00100, ram1_we low 2 cycles; read ack 3 cycles after accept with rdata=16'hBEEF.
- Read 16'h9000 with model holding 16'h1234 → RAM2 strobes toggle, RAM1 en stays 1, rdata=16'h1234, ack exactly one cycle.
- NUM_UART=2, uart_data_ready=2'b10, ram1_data[7:0]=8'h41:
  - read 16'hBF02 → uart_rdn[1] low 2 cycles, rdata=16'h0041
  - read 16'hBF00 → rdata=0 with no rdn pulse.
- Write 16'hBF00 with data 16'h1255, tbre[0]&tsre[0] held 0 for 10 cycles → ram1_data=16'h0055, wrn[0] low 1 cycle, busy high until 1 cycle after tbre&tsre rise; then ack.
- Read 16'hBF05 (channel 2, status, NUM_UART=2) → rdata=0, ack next cycle, no strobes. Also assert req continuously while busy → exactly one access per ack.

Source files
------------

// File: rtl/mem_ctrl_multi.sv
// Data-memory controller for the MEM stage: routes one CPU word access to
// RAM1, a memory-mapped UART channel or RAM2, with a req/ack handshake,
// programmable SRAM wait states and a pipeline stall output.
module mem_ctrl_multi #(
    parameter int          DATA_W      = 16,
    parameter int          RAM_AW      = 18,
    parameter logic [15:0] RAM1_UPPER  = 16'h8000,
    parameter logic [15:0] UART_BASE   = 16'hBF00,
    parameter int          NUM_UART    = 2,
    parameter int          WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic                we,
    input  logic [15:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                busy,
    inout  wire  [DATA_W-1:0]   ram1_data,
    output logic [RAM_AW-1:0]   ram1_addr,
    output logic                ram1_en,
    output logic                ram1_oe,
    output logic                ram1_we,
    inout  wire  [DATA_W-1:0]   ram2_data,
    output logic [RAM_AW-1:0]   ram2_addr,
    output logic                ram2_en,
    output logic                ram2_oe,
    output logic                ram2_we,
    input  logic [NUM_UART-1:0] uart_data_ready,
    input  logic [NUM_UART-1:0] uart_tbre,
    input  logic [NUM_UART-1:0] uart_tsre,
    output logic [NUM_UART-1:0] uart_rdn,
    output logic [NUM_UART-1:0] uart_wrn
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SRAM_ACC  = 3'd1;
    localparam logic [2:0] SRAM_HOLD = 3'd2;
    localparam logic [2:0] U_RD      = 3'd3;
    localparam logic [2:0] U_WR      = 3'd4;
    localparam logic [2:0] U_TXWAIT  = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;

    logic [2:0]          state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                ram2Sel_q, ram2Sel_d;
    logic [1:0]          ch_q, ch_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [RAM_AW-1:0]   ram1Addr_q, ram1Addr_d, ram2Addr_q, ram2Addr_d;
    logic                ack_q, ack_d, busy_q, busy_d;
    logic                ram1En_q, ram1En_d, ram1Oe_q, ram1Oe_d, ram1We_q, ram1We_d;
    logic                ram2En_q, ram2En_d, ram2Oe_q, ram2Oe_d, ram2We_q, ram2We_d;
    logic                ram1Drv_q, ram1Drv_d, ram2Drv_q, ram2Drv_d;
    logic [NUM_UART-1:0] rdn_q, rdn_d, wrn_q, wrn_d;

    logic [3:0] readyPad, txEmptyPad, chSel;
    logic [2:0] slot;
    logic       inWindow, sramAct;

    // Per-channel status padded to four lanes so a 2-bit channel index is always in range
    assign readyPad   = 4'(uart_data_ready);
    assign txEmptyPad = 4'(uart_tbre & uart_tsre);
    assign slot       = 3'(addr - UART_BASE);
    assign inWindow   = (addr >= UART_BASE) && ({1'b0, addr} < ({1'b0, UART_BASE} + 17'd8));

    assign ram1_data = ram1Drv_q ? dout_q : 'z;
    assign ram2_data = ram2Drv_q ? dout_q : 'z;
    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign ram1_addr = ram1Addr_q;
    assign ram1_en   = ram1En_q;
    assign ram1_oe   = ram1Oe_q;
    assign ram1_we   = ram1We_q;
    assign ram2_addr = ram2Addr_q;
    assign ram2_en   = ram2En_q;
    assign ram2_oe   = ram2Oe_q;
    assign ram2_we   = ram2We_q;
    assign uart_rdn  = rdn_q;
    assign uart_wrn  = wrn_q;

    // Sequencer: accept/decode, wait-state counting, data capture, then next-cycle strobes from the next state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        ram2Sel_d  = ram2Sel_q;
        ch_d       = ch_q;
        rdata_d    = rdata_q;
        dout_d     = dout_q;
        ram1Addr_d = ram1Addr_q;
        ram2Addr_d = ram2Addr_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    we_d   = we;
                    cnt_d  = '0;
                    dout_d = wdata;
                    if (addr < RAM1_UPPER) begin
                        ram2Sel_d  = 1'b0;
                        ram1Addr_d = RAM_AW'(addr);
                        state_d    = SRAM_ACC;
                    end else if (inWindow) begin
                        ch_d   = slot[2:1];
                        dout_d = {{(DATA_W-8){1'b0}}, wdata[7:0]};
                        if (int'(slot[2:1]) >= NUM_UART) begin
                            state_d = DONE;
                            if (!we) rdata_d = '0;
                        end else if (slot[0]) begin
                            state_d = DONE;
                            if (!we) rdata_d = {{(DATA_W-2){1'b0}}, readyPad[slot[2:1]], txEmptyPad[slot[2:1]]};
                        end else if (we) begin
                            state_d = U_WR;
                        end else if (readyPad[slot[2:1]]) begin
                            state_d = U_RD;
                        end else begin
                            rdata_d = '0;
                            state_d = DONE;
                        end
                    end else begin
                        ram2Sel_d  = 1'b1;
                        ram2Addr_d = RAM_AW'(addr);
                        state_d    = SRAM_ACC;
                    end
                end
            end
            SRAM_ACC: begin
                if (cnt_q == 3'(WAIT_STATES)) begin
                    if (we_q) begin
                        state_d = SRAM_HOLD;
                    end else begin
                        rdata_d = ram2Sel_q ? ram2_data : ram1_data;
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            SRAM_HOLD: state_d = DONE;
            U_RD: begin
                if (cnt_q == 3'd1) begin
                    rdata_d = {{(DATA_W-8){1'b0}}, ram1_data[7:0]};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            U_WR:     state_d = U_TXWAIT;
            U_TXWAIT: if (txEmptyPad[ch_q]) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        sramAct   = (state_d == SRAM_ACC) || (state_d == SRAM_HOLD);
        ram1En_d  = !(sramAct && !ram2Sel_d);
        ram1Oe_d  = !((state_d == SRAM_ACC) && !we_d && !ram2Sel_d);
        ram1We_d  = !((state_d == SRAM_ACC) && we_d && !ram2Sel_d);
        ram1Drv_d = (sramAct && we_d && !ram2Sel_d) || (state_d == U_WR) || (state_d == U_TXWAIT);
        ram2En_d  = !(sramAct && ram2Sel_d);
        ram2Oe_d  = !((state_d == SRAM_ACC) && !we_d && ram2Sel_d);
        ram2We_d  = !((state_d == SRAM_ACC) && we_d && ram2Sel_d);
        ram2Drv_d = sramAct && we_d && ram2Sel_d;
        for (int i = 0; i < 4; i++) chSel[i] = (ch_d == 2'(i));
        rdn_d  = ~(chSel[NUM_UART-1:0] & {NUM_UART{state_d == U_RD}});
        wrn_d  = ~(chSel[NUM_UART-1:0] & {NUM_UART{state_d == U_WR}});
        ack_d  = (state_d == DONE);
        busy_d = (state_d != IDLE);
    end

    // State and all outputs registered; reset idles every strobe and releases both buses at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            ram2Sel_q  <= 1'b0;
            ch_q       <= '0;
            rdata_q    <= '0;
            dout_q     <= '0;
            ram1Addr_q <= '0;
            ram2Addr_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            ram1En_q   <= 1'b1;
            ram1Oe_q   <= 1'b1;
            ram1We_q   <= 1'b1;
            ram2En_q   <= 1'b1;
            ram2Oe_q   <= 1'b1;
            ram2We_q   <= 1'b1;
            ram1Drv_q  <= 1'b0;
            ram2Drv_q  <= 1'b0;
            rdn_q      <= '1;
            wrn_q      <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            ram2Sel_q  <= ram2Sel_d;
            ch_q       <= ch_d;
            rdata_q    <= rdata_d;
            dout_q     <= dout_d;
            ram1Addr_q <= ram1Addr_d;
            ram2Addr_q <= ram2Addr_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            ram1En_q   <= ram1En_d;
            ram1Oe_q   <= ram1Oe_d;
            ram1We_q   <= ram1We_d;
            ram2En_q   <= ram2En_d;
            ram2Oe_q   <= ram2Oe_d;
            ram2We_q   <= ram2We_d;
            ram1Drv_q  <= ram1Drv_d;
            ram2Drv_q  <= ram2Drv_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
        end
    end

endmodule
